boolfn_pipe: RTL and testbench

BOOLFN_PIPE -- requirements
Module: boolfn_pipe

---
 rtl/boolfn_pipe.sv | 154 +++++++++++++++
 tb/tb_boolfn_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boolfn_pipe.sv
// Two-stage pipelined 2-input boolean function unit with BITWISE, REDUCE and
// ACCUM (XOR-accumulate burst) modes, valid/ready handshakes and a sticky error flag.
module boolfn_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       tt,
    input  logic [1:0]       mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_par,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_BITWISE = 2'd0,
        MODE_REDUCE  = 2'd1,
        MODE_ACCUM   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_tt;
    mode_t            s1_mode;
    logic             s1_last;

    logic             s2_valid;
    logic [WIDTH-1:0] y_reg;
    logic             y_par_reg;

    logic [WIDTH-1:0] acc_reg;
    logic             open_reg;
    logic             err_reg;

    logic             advance;
    logic [WIDTH-1:0] f;
    logic [WIDTH+1:0] red_wide;
    logic [WIDTH-1:0] y_next;
    logic             emit;
    logic [WIDTH-1:0] acc_next;
    logic             open_next;
    logic             err_set;

    assign advance  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || advance;

    assign out_valid = s2_valid;
    assign y         = y_reg;
    assign y_par     = y_par_reg;
    assign err       = err_reg;

    // Each result bit looks up the truth table with {a,b} as the index.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fn
            assign f[gi] = s1_tt[{s1_a[gi], s1_b[gi]}];
        end
    endgenerate

    // Padded by two bits so the reduce layout stays legal even at WIDTH=2.
    always_comb begin
        red_wide    = '0;
        red_wide[0] = |f;
        red_wide[1] = &f;
        red_wide[2] = ^f;
    end

    always_comb begin
        y_next    = f;
        emit      = 1'b0;
        acc_next  = acc_reg;
        open_next = open_reg;
        err_set   = 1'b0;
        case (s1_mode)
            MODE_ACCUM: begin
                if (s1_last) begin
                    y_next    = acc_reg ^ f;
                    emit      = 1'b1;
                    acc_next  = '0;
                    open_next = 1'b0;
                end else begin
                    acc_next  = acc_reg ^ f;
                    open_next = 1'b1;
                end
            end
            default: begin
                emit = 1'b1;
                // A non-ACCUM beat interrupting an open burst abandons it.
                if (open_reg) begin
                    err_set   = 1'b1;
                    acc_next  = '0;
                    open_next = 1'b0;
                end
                if (s1_mode == MODE_RSVD) begin
                    err_set = 1'b1;
                end
                if (s1_mode == MODE_REDUCE) begin
                    y_next = red_wide[WIDTH-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tt    <= '0;
            s1_mode  <= MODE_BITWISE;
            s1_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_tt    <= tt;
            s1_mode  <= mode_t'(mode);
            s1_last  <= in_last;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            y_reg     <= '0;
            y_par_reg <= 1'b0;
            acc_reg   <= '0;
            open_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid && emit;
            if (s1_valid && emit) begin
                y_reg     <= y_next;
                y_par_reg <= ^y_next;
            end
            if (s1_valid) begin
                acc_reg  <= acc_next;
                open_reg <= open_next;
                err_reg  <= err_reg | err_set;
            end
        end
    end

endmodule

// File: tb/tb_boolfn_pipe.sv
// Scoreboard bench for boolfn_pipe: directed scenarios then randomized traffic
// with random backpressure, checked against a beat-level reference model.
module tb_boolfn_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   tt;
    logic [1:0]   mode;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         y_par;
    logic         err;

    boolfn_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .tt        (tt),
        .mode      (mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_par     (y_par),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_acc;
    logic         m_open;
    logic         m_err;
    logic         rand_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bit i of the function is the truth-table entry numbered a[i]*2+b[i].
    function automatic logic [W-1:0] ref_fn(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                            input logic [3:0] ftt);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = ftt[int'(fa[i]) * 2 + int'(fb[i])];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] ref_reduce(input logic [W-1:0] fv);
        logic [W-1:0] r;
        int ones;
        ones = $countones(fv);
        r = '0;
        r[0] = (ones != 0);
        r[1] = (ones == W);
        r[2] = (ones % 2 == 1);
        return r;
    endfunction

    // Beats are processed strictly in order, so the model can act at acceptance.
    task automatic model_accept(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic [3:0] mtt, input logic [1:0] mm, input logic ml);
        logic [W-1:0] fv;
        fv = ref_fn(ma, mb, mtt);
        if (mm == 2'd2) begin
            if (ml) begin
                exp_q.push_back(m_acc ^ fv);
                m_acc  = '0;
                m_open = 1'b0;
            end else begin
                m_acc  = m_acc ^ fv;
                m_open = 1'b1;
            end
        end else begin
            if (m_open) begin
                m_err  = 1'b1;
                m_acc  = '0;
                m_open = 1'b0;
            end
            if (mm == 2'd3) m_err = 1'b1;
            exp_q.push_back(mm == 2'd1 ? ref_reduce(fv) : fv);
        end
    endtask

    task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic [3:0] stt,
                        input logic [1:0] sm, input logic sl);
        int  waited;
        logic done;
        waited   = 0;
        done     = 1'b0;
        a        = sa;
        b        = sb;
        tt       = stt;
        mode     = sm;
        in_last  = sl;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(sa, sb, stt, sm, sl);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        chk("err_flag", 32'(err), 32'(m_err));
    endtask

    // Monitor: pop and compare on every handshake; also checks output hold while stalled.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_y;
    logic         prev_par;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_y", 32'(y), 32'(prev_y));
                chk("hold_par", 32'(y_par), 32'(prev_par));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(y), 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("y", 32'(y), 32'(e));
                    chk("y_par", 32'(y_par), 32'(^e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            prev_par   = y_par;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [W-1:0] exp_first;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        tt        = '0;
        mode      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rand_rdy  = 1'b0;
        m_acc     = '0;
        m_open    = 1'b0;
        m_err     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_y_par", 32'(y_par), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // First beat is offered on the very first edge after reset release.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'hF0, 8'hCC, 4'b1000, 2'd0, 1'b0);
        send(8'hF0, 8'hCC, 4'b0110, 2'd0, 1'b0);
        send(8'hFF, 8'hFF, 4'b1000, 2'd1, 1'b0);
        send(8'h01, 8'h00, 4'b1110, 2'd1, 1'b0);
        drain();
        chk("ref_and", 32'(ref_fn(8'hF0, 8'hCC, 4'b1000)), 32'hC0);

        send(8'h01, 8'h00, 4'b0110, 2'd2, 1'b0);
        send(8'h02, 8'h00, 4'b0110, 2'd2, 1'b0);
        send(8'h04, 8'h00, 4'b0110, 2'd2, 1'b1);
        send(8'h00, 8'h00, 4'b0110, 2'd2, 1'b1);
        drain();

        // Backpressure: two beats fill the pipe, the third must stall.
        out_ready = 1'b0;
        exp_first = ref_fn(8'h12, 8'h34, 4'b0110);
        send(8'h12, 8'h34, 4'b0110, 2'd0, 1'b0);
        send(8'h56, 8'h78, 4'b1110, 2'd0, 1'b0);
        a = 8'h9A; b = 8'hBC; tt = 4'b0111; mode = 2'd0; in_last = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_y_frozen", 32'(y), 32'(exp_first));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h9A, 8'hBC, 4'b0111, 2'd0, 1'b0);
        drain();

        send(8'h33, 8'h0F, 4'b0110, 2'd2, 1'b0);
        send(8'hA5, 8'h5A, 4'b1000, 2'd0, 1'b0);
        drain();
        send(8'hC3, 8'h3C, 4'b1110, 2'd3, 1'b0);
        drain();

        // Asynchronous reset mid-burst, asserted away from any clock edge.
        send(8'h11, 8'h00, 4'b0110, 2'd2, 1'b0);
        send(8'h22, 8'h00, 4'b0110, 2'd2, 1'b0);
        @(posedge clk);
        #3;
        chk("pre_rst_err", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        m_acc  = '0;
        m_open = 1'b0;
        m_err  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h0F, 8'h00, 4'b0110, 2'd2, 1'b1);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int gap;
            logic [1:0] rm;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            rm = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            send(W'($urandom), W'($urandom), 4'($urandom), rm, ($urandom_range(0, 2) == 0));
        end
        drain();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
